// File: rtl/sd_init.sv
// SPI-mode SD card power-up and init sequencer.
// Drives CMD0/CMD8/CMD55+ACMD41/CMD58 and reports ready or failure.
module sd_init #(
  parameter int unsigned POWERUP_CLKS = 80,
  parameter int unsigned RESP_TIMEOUT = 64,
  parameter int unsigned GAP_CLKS     = 8,
  parameter int unsigned ACMD41_RETRY = 4095
) (
  input  logic       rst_n,
  input  logic       SD_CK,
  input  logic       SD_MISO,
  output logic       SD_MOSI,
  output logic       SD_CSn,
  output logic       init_o,
  output logic       init_err,
  output logic [2:0] err_code,
  output logic       card_hc
);

  typedef enum logic [2:0] {
    S_PWR, S_SEND, S_WAIT, S_RECV, S_GAP, S_DONE, S_ERR
  } state_e;

  typedef enum logic [2:0] {
    C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58, C_FIN
  } cmd_e;

  localparam logic [15:0] PWR_LAST = 16'(POWERUP_CLKS - 1);
  localparam logic [15:0] TO_LAST  = 16'(RESP_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CLKS - 1);
  localparam logic [15:0] RETRY    = 16'(ACMD41_RETRY);

  function automatic logic [47:0] frame(cmd_e c);
    case (c)
      C_CMD0:   frame = 48'h40_0000_0000_95;
      C_CMD8:   frame = 48'h48_0000_01AA_87;
      C_CMD55:  frame = 48'h77_0000_0000_FF;
      C_ACMD41: frame = 48'h69_4000_0000_FF;
      default:  frame = 48'h7A_0000_0000_FF;
    endcase
  endfunction

  function automatic logic [2:0] code_of(cmd_e c);
    case (c)
      C_CMD0:   code_of = 3'd1;
      C_CMD8:   code_of = 3'd2;
      C_CMD55:  code_of = 3'd3;
      C_ACMD41: code_of = 3'd4;
      default:  code_of = 3'd5;
    endcase
  endfunction

  state_e      state_q, state_d;
  cmd_e        cmd_q, cmd_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] retry_q, retry_d;
  logic [47:0] tx_q, tx_d;
  logic [39:0] rx_q, rx_d;
  logic        csn_q, csn_d;
  logic        mosi_q, mosi_d;
  logic        init_q, init_d;
  logic        err_q, err_d;
  logic [2:0]  code_q, code_d;
  logic        hc_q, hc_d;
  logic        miso_q;

  logic [39:0] resp;
  logic [7:0]  r1;
  logic [15:0] last_idx;
  logic        r7;
  logic        go;
  logic        fail;
  logic        adv;
  cmd_e        nxt;
  logic [47:0] fr;

  // MISO is captured on the rising edge; the FSM consumes it one half-cycle later.
  always_ff @(posedge SD_CK or negedge rst_n) begin
    if (!rst_n) miso_q <= 1'b1;
    else        miso_q <= SD_MISO;
  end

  always_comb begin
    r7       = (cmd_q == C_CMD8) || (cmd_q == C_CMD58);
    resp     = {rx_q[38:0], miso_q};
    r1       = r7 ? resp[39:32] : resp[7:0];
    last_idx = r7 ? 16'd39 : 16'd7;
    fr       = frame(cmd_q);
    state_d  = state_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    csn_d    = csn_q;
    mosi_d   = mosi_q;
    init_d   = init_q;
    err_d    = err_q;
    code_d   = code_q;
    hc_d     = hc_q;
    go       = 1'b0;
    fail     = 1'b0;
    adv      = 1'b0;
    nxt      = cmd_q;

    unique case (state_q)
      S_PWR: begin
        if (cnt_q == PWR_LAST) go = 1'b1;
        else cnt_d = cnt_q + 16'd1;
      end
      S_SEND: begin
        if (cnt_q == 16'd47) begin
          mosi_d  = 1'b1;
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          mosi_d = tx_q[47];
          tx_d   = {tx_q[46:0], 1'b1};
          cnt_d  = cnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        if (!miso_q) begin
          state_d = S_RECV;
          rx_d    = '0;
          cnt_d   = 16'd1;
        end else if (cnt_q == TO_LAST) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RECV: begin
        if (cnt_q != last_idx) begin
          rx_d  = resp;
          cnt_d = cnt_q + 16'd1;
        end else begin
          case (cmd_q)
            C_CMD0: begin
              adv  = (r1 == 8'h01);
              nxt  = C_CMD8;
            end
            C_CMD8: begin
              adv  = (r1 == 8'h01) && (resp[11:0] == 12'h1AA);
              nxt  = C_CMD55;
            end
            C_CMD55: begin
              adv  = (r1 == 8'h01) || (r1 == 8'h00);
              nxt  = C_ACMD41;
            end
            C_ACMD41: begin
              if (r1 == 8'h00) begin
                adv = 1'b1;
                nxt = C_CMD58;
              end else if (r1 == 8'h01 && retry_q + 16'd1 != RETRY) begin
                adv     = 1'b1;
                nxt     = C_CMD55;
                retry_d = retry_q + 16'd1;
              end
            end
            C_CMD58: begin
              adv = (r1 == 8'h00);
              nxt = C_FIN;
              if (adv) hc_d = resp[30];
            end
            default: adv = 1'b0;
          endcase
          fail = !adv;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) go = 1'b1;
        else cnt_d = cnt_q + 16'd1;
      end
      default: ;
    endcase

    if (adv) begin
      state_d = S_GAP;
      cmd_d   = nxt;
      cnt_d   = '0;
      csn_d   = 1'b1;
      mosi_d  = 1'b1;
    end

    if (fail) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      code_d  = code_of(cmd_q);
      csn_d   = 1'b1;
      mosi_d  = 1'b1;
    end

    if (go) begin
      if (cmd_q == C_FIN) begin
        state_d = S_DONE;
        init_d  = 1'b1;
      end else begin
        state_d = S_SEND;
        csn_d   = 1'b0;
        mosi_d  = fr[47];
        tx_d    = {fr[46:0], 1'b1};
        cnt_d   = '0;
      end
    end
  end

  always_ff @(negedge SD_CK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PWR;
      cmd_q   <= C_CMD0;
      cnt_q   <= '0;
      retry_q <= '0;
      tx_q    <= '1;
      rx_q    <= '0;
      csn_q   <= 1'b1;
      mosi_q  <= 1'b1;
      init_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
      hc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      csn_q   <= csn_d;
      mosi_q  <= mosi_d;
      init_q  <= init_d;
      err_q   <= err_d;
      code_q  <= code_d;
      hc_q    <= hc_d;
    end
  end

  assign SD_CSn   = csn_q;
  assign SD_MOSI  = mosi_q;
  assign init_o   = init_q;
  assign init_err = err_q;
  assign err_code = code_q;
  assign card_hc  = hc_q;

endmodule

// File: tb/tb_sd_init.sv
// Bench for sd_init: behavioural SD card plus sequence-level reference.
// dut_b uses a 3-pair ACMD41 retry limit; only the selected DUT runs.
module tb_sd_init;

  localparam int TO = 64;

  logic SD_CK = 1'b0;
  always #5 SD_CK = ~SD_CK;

  logic       rst_a, rst_b, sel;
  logic       miso;
  logic       mosi_a, csn_a, init_a, err_a, hc_a;
  logic       mosi_b, csn_b, init_b, err_b, hc_b;
  logic [2:0] code_a, code_b;

  sd_init dut_a (
    .rst_n(rst_a), .SD_CK(SD_CK), .SD_MISO(miso),
    .SD_MOSI(mosi_a), .SD_CSn(csn_a), .init_o(init_a),
    .init_err(err_a), .err_code(code_a), .card_hc(hc_a)
  );

  sd_init #(.ACMD41_RETRY(3)) dut_b (
    .rst_n(rst_b), .SD_CK(SD_CK), .SD_MISO(miso),
    .SD_MOSI(mosi_b), .SD_CSn(csn_b), .init_o(init_b),
    .init_err(err_b), .err_code(code_b), .card_hc(hc_b)
  );

  wire       rst_s  = sel ? rst_b  : rst_a;
  wire       mosi_s = sel ? mosi_b : mosi_a;
  wire       csn_s  = sel ? csn_b  : csn_a;
  wire       init_s = sel ? init_b : init_a;
  wire       err_s  = sel ? err_b  : err_a;
  wire [2:0] code_s = sel ? code_b : code_a;
  wire       hc_s   = sel ? hc_b   : hc_a;

  // card behaviour knobs
  bit          c0_silent, a41_always;
  logic [7:0]  c0_r1, c8_r1, c55_r1, c58_r1;
  logic [31:0] c8_echo, ocr;
  int          n_busy;

  // card state
  logic [47:0] sh;
  logic [39:0] rsp;
  int          rxcnt, len, pos, dly, pairs, lead, post;
  bit          busy, silent, lead_done, counting, in_a41;
  int          last_cmd;
  int          log_q[$];

  // reference outcome
  int          exp_q[$];
  bit          exp_init, exp_err, exp_hc;
  logic [2:0]  exp_code;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic int pick_lat();
    int r;
    r = int'($urandom_range(0, 7));
    if (r == 0) return 1;
    if (r < 3) return TO;
    return int'($urandom_range(1, TO));
  endfunction

  always @(posedge SD_CK or negedge SD_CK) begin
    if (!rst_s) begin
      rxcnt = 0; busy = 0; pairs = 0; lead = 0; lead_done = 0;
      post = 0; counting = 0; in_a41 = 0; miso = 1'b1;
      last_cmd = -1; log_q.delete();
    end else if (SD_CK) begin
      if (!lead_done) begin
        if (csn_s) lead++;
        else lead_done = 1;
      end
      if (counting) begin
        if (!err_s && !init_s) post++;
        else counting = 0;
      end
      if (csn_s) begin
        rxcnt = 0; busy = 0; in_a41 = 0;
      end else if (!busy) begin
        sh = {sh[46:0], mosi_s};
        rxcnt++;
        if (rxcnt == 48) begin
          silent = 0;
          len = 8;
          case (sh)
            48'h40_0000_0000_95: begin
              last_cmd = 0;
              silent = c0_silent;
              rsp = {32'h0, c0_r1};
            end
            48'h48_0000_01AA_87: begin
              last_cmd = 8;
              rsp = {c8_r1, c8_echo};
              len = 40;
            end
            48'h77_0000_0000_FF: begin
              last_cmd = 55;
              rsp = {32'h0, c55_r1};
            end
            48'h69_4000_0000_FF: begin
              last_cmd = 41;
              pairs++;
              rsp = (a41_always || pairs <= n_busy) ? 40'h01 : 40'h00;
            end
            48'h7A_0000_0000_FF: begin
              last_cmd = 58;
              rsp = {c58_r1, ocr};
              len = 40;
            end
            default: begin
              last_cmd = 99;
              silent = 1;
            end
          endcase
          log_q.push_back(last_cmd);
          busy = 1; pos = 0; dly = pick_lat();
          post = 0; counting = 1;
        end
      end
    end else begin
      if (busy && !silent) begin
        if (dly > 1) begin
          dly--;
          miso = 1'b1;
        end else if (pos < len) begin
          miso = rsp[len-1-pos];
          pos++;
          if (last_cmd == 41 && pos >= 3) in_a41 = 1;
        end else begin
          miso = 1'b1;
        end
      end else begin
        miso = 1'b1;
      end
    end
  end

  task automatic set_good();
    c0_silent = 0; c0_r1 = 8'h01;
    c8_r1 = 8'h01; c8_echo = 32'h0000_01AA;
    c55_r1 = 8'h01; a41_always = 0; n_busy = 3;
    c58_r1 = 8'h00; ocr = 32'hC0FF_8000;
  endtask

  // Expected command trace and outcome from the card's answers.
  task automatic model(input int retry);
    bit ok41;
    exp_q.delete();
    exp_init = 0; exp_err = 0; exp_hc = 0; exp_code = 3'd0;
    exp_q.push_back(0);
    if (c0_silent || c0_r1 != 8'h01) begin
      exp_err = 1; exp_code = 3'd1; return;
    end
    exp_q.push_back(8);
    if (c8_r1 != 8'h01 || c8_echo[11:0] != 12'h1AA) begin
      exp_err = 1; exp_code = 3'd2; return;
    end
    ok41 = 0;
    for (int p = 1; p <= retry; p++) begin
      exp_q.push_back(55);
      if (c55_r1 > 8'h01) begin
        exp_err = 1; exp_code = 3'd3; return;
      end
      exp_q.push_back(41);
      if (!(a41_always || p <= n_busy)) begin
        ok41 = 1;
        break;
      end
    end
    if (!ok41) begin
      exp_err = 1; exp_code = 3'd4; return;
    end
    exp_q.push_back(58);
    if (c58_r1 != 8'h00) begin
      exp_err = 1; exp_code = 3'd5; return;
    end
    exp_init = 1;
    exp_hc = ocr[30];
  endtask

  task automatic start(input bit b);
    rst_a = 1'b0;
    rst_b = 1'b0;
    sel = b;
    model(b ? 3 : 4095);
    repeat (4) @(negedge SD_CK);
    #1;
    if (b) rst_b = 1'b1;
    else   rst_a = 1'b1;
  endtask

  task automatic finish_run(input string nm);
    int cyc;
    int a41s;
    cyc = 0;
    while (!(init_s || err_s) && cyc < 20000) begin
      @(posedge SD_CK);
      cyc++;
    end
    chk({nm, ".bound"}, 64'(cyc < 20000), 64'd1);
    repeat (20) @(posedge SD_CK);
    #1;
    chk({nm, ".init"}, 64'(init_s), 64'(exp_init));
    chk({nm, ".err"}, 64'(err_s), 64'(exp_err));
    chk({nm, ".code"}, 64'(code_s), 64'(exp_code));
    chk({nm, ".hc"}, 64'(hc_s), 64'(exp_hc));
    chk({nm, ".idle"}, {62'd0, csn_s, mosi_s}, 64'd3);
    chk({nm, ".lead"}, 64'(lead), 64'd80);
    chk({nm, ".ncmd"}, 64'(log_q.size()), 64'(exp_q.size()));
    a41s = 0;
    foreach (exp_q[i]) if (exp_q[i] == 41) a41s++;
    chk({nm, ".pairs"}, 64'(pairs), 64'(a41s));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s.cmd%0d", nm, i), 64'(log_q[i]), 64'(exp_q[i]));
  endtask

  task automatic reset_check(input string nm);
    @(posedge SD_CK);
    #3;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    chk({nm, ".rst"},
        {57'd0, csn_s, mosi_s, init_s, err_s, code_s, hc_s},
        {57'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0});
  endtask

  initial begin
    logic [7:0] bad[4];
    int k, cyc;
    bad[0] = 8'h05; bad[1] = 8'h04; bad[2] = 8'h09; bad[3] = 8'h7F;
    rst_a = 1'b0; rst_b = 1'b0; sel = 1'b0;
    set_good();
    repeat (2) @(negedge SD_CK);
    #1;
    chk("por", {59'd0, csn_a, mosi_a, init_a, err_a, hc_a},
        {59'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});

    set_good();
    start(0);
    finish_run("sdhc");
    reset_check("sdhc");

    set_good();
    ocr = 32'h80FF_8000;
    n_busy = 1;
    start(0);
    finish_run("sdsc");

    set_good();
    c0_silent = 1;
    start(0);
    finish_run("c0_to");
    chk("c0_to.edges", 64'(post), 64'(TO));

    set_good();
    c8_r1 = 8'h05;
    c8_echo = 32'hFFFF_FFFF;
    start(0);
    finish_run("c8_v1");

    set_good();
    c8_echo = 32'h0000_01AB;
    start(0);
    finish_run("c8_echo");

    set_good();
    a41_always = 1;
    start(1);
    finish_run("a41_retry");

    set_good();
    c55_r1 = 8'h05;
    start(0);
    finish_run("c55_bad");

    set_good();
    c58_r1 = 8'h01;
    start(1);
    finish_run("c58_bad");

    set_good();
    start(0);
    cyc = 0;
    while (!in_a41 && cyc < 20000) begin
      @(negedge SD_CK);
      cyc++;
    end
    chk("mid.reach", 64'(in_a41), 64'd1);
    chk("mid.csn_low", 64'(csn_a), 64'd0);
    reset_check("mid");
    repeat (3) @(negedge SD_CK);
    #1;
    rst_a = 1'b1;
    finish_run("mid");

    for (int it = 0; it < 6; it++) begin
      set_good();
      n_busy = int'($urandom_range(0, 4));
      ocr = $urandom();
      ocr[31] = 1'b1;
      k = int'($urandom_range(0, 6));
      case (k)
        1: c0_r1 = ($urandom_range(0, 1) == 0) ? 8'h00 : bad[$urandom_range(0, 3)];
        2: c8_echo = 32'h0000_01AA ^ (32'd1 << $urandom_range(0, 11));
        3: c55_r1 = bad[$urandom_range(0, 3)];
        4: c58_r1 = bad[$urandom_range(0, 3)];
        5: c8_r1 = bad[$urandom_range(0, 3)];
        default: ;
      endcase
      start(1'($urandom_range(0, 1)));
      finish_run($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
